multi_clock_divider: RTL and testbench

//  NUM_CH independent integer clock dividers sharing one system clock. Each channel's divisor and mode are

---
 rtl/multi_clock_divider_pkg.sv | 22 ++
 rtl/multi_clock_divider_channel.sv | 184 ++++++++++++++++++
 rtl/multi_clock_divider.sv | 75 +++++++
 tb/tb_multi_clock_divider.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   mode_e         : channel output mode (toggle square wave or pulse strobe)
//   DEFAULT_DIV_C  : divisor loaded at reset (1 Hz toggle from a 100 MHz clock)
//   ch_idx_w()     : width of the channel-select field, never narrower than 1
package multi_clock_divider_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int DEFAULT_DIV_C = 50_000_000;

  function automatic int ch_idx_w(input int num_ch);
    if (num_ch > 1) begin
      return $clog2(num_ch);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: counter, active divisor/mode (and high time), a single
// pending-update slot, and registered divided_clk / tick outputs.
// Optional feature macro: CLKDIV_DUTY_EN (adds programmable PULSE high time).
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   enable          count enable (low freezes counter and output, tick low)
//   restart         phase-align: counter 0, outputs 0, pending applied now
//   wr_en           accepted config write for this channel
//   wr_div/wr_mode  new divisor / mode (wr_high with CLKDIV_DUTY_EN)
//   pending         update waiting for the next terminal count
//   divided_clk     registered divided output
//   tick            registered one-cycle terminal-count strobe
module clkdiv_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  mode_e            wr_mode,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] wr_high,
`endif
  output logic             pending,
  output logic             divided_clk,
  output logic             tick
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] count_r, div_r, pdiv_r;
  logic [CNT_W-1:0] count_s, div_s, pdiv_s;
  mode_e            mode_r, pmode_r, mode_s, pmode_s;
  logic             pend_r, pend_s, clk_r, clk_s, tick_r, tick_s;
  logic             terminal_s;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] high_r, phigh_r, high_s, phigh_s;
`endif

  assign terminal_s  = enable && (div_r != CNT_ZERO) && (count_r == div_r - CNT_ONE);
  assign pending     = pend_r;
  assign divided_clk = clk_r;
  assign tick        = tick_r;

  // Next-state: restart > stopped channel > freeze > terminal > count.
  always_comb begin
    count_s = count_r;
    div_s   = div_r;
    mode_s  = mode_r;
    pend_s  = pend_r;
    pdiv_s  = pdiv_r;
    pmode_s = pmode_r;
    clk_s   = clk_r;
    tick_s  = 1'b0;
`ifdef CLKDIV_DUTY_EN
    high_s  = high_r;
    phigh_s = phigh_r;
`endif
    if (restart) begin
      count_s = CNT_ZERO;
      clk_s   = 1'b0;
      pend_s  = 1'b0;
      // A write on the restart edge wins over an older pending value.
      if (wr_en) begin
        div_s  = wr_div;
        mode_s = wr_mode;
`ifdef CLKDIV_DUTY_EN
        high_s = wr_high;
`endif
      end else if (pend_r) begin
        div_s  = pdiv_r;
        mode_s = pmode_r;
`ifdef CLKDIV_DUTY_EN
        high_s = phigh_r;
`endif
      end else begin
        div_s  = div_r;
      end
    end else begin
      if (div_r == CNT_ZERO) begin
        // Stopped channel: no terminal will ever come, so apply on any edge.
        count_s = CNT_ZERO;
        clk_s   = 1'b0;
        if (pend_r) begin
          div_s  = pdiv_r;
          mode_s = pmode_r;
`ifdef CLKDIV_DUTY_EN
          high_s = phigh_r;
`endif
          pend_s = 1'b0;
        end else begin
          pend_s = pend_r;
        end
      end else if (!enable) begin
        count_s = count_r;
      end else if (terminal_s) begin
        count_s = CNT_ZERO;
        tick_s  = 1'b1;
        if (pend_r) begin
          div_s  = pdiv_r;
          mode_s = pmode_r;
`ifdef CLKDIV_DUTY_EN
          high_s = phigh_r;
`endif
          pend_s = 1'b0;
        end else begin
          pend_s = pend_r;
        end
        if (pend_r && (pmode_r != mode_r)) begin
          clk_s = 1'b0;
        end else if (mode_s == MODE_TOGGLE) begin
          clk_s = ~clk_r;
        end else begin
`ifdef CLKDIV_DUTY_EN
          clk_s = (count_s < high_s);
`else
          clk_s = 1'b1;
`endif
        end
      end else begin
        count_s = count_r + CNT_ONE;
        if (mode_r == MODE_TOGGLE) begin
          clk_s = clk_r;
        end else begin
`ifdef CLKDIV_DUTY_EN
          clk_s = (count_s < high_r);
`else
          clk_s = 1'b0;
`endif
        end
      end
      // The top only asserts wr_en when the slot is empty.
      if (wr_en) begin
        pdiv_s  = wr_div;
        pmode_s = wr_mode;
`ifdef CLKDIV_DUTY_EN
        phigh_s = wr_high;
`endif
        pend_s  = 1'b1;
      end else begin
        pdiv_s  = pdiv_r;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
      div_r   <= DEF_DIV;
      mode_r  <= MODE_TOGGLE;
      pend_r  <= 1'b0;
      pdiv_r  <= DEF_DIV;
      pmode_r <= MODE_TOGGLE;
      clk_r   <= 1'b0;
      tick_r  <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      high_r  <= CNT_ONE;
      phigh_r <= CNT_ONE;
`endif
    end else begin
      count_r <= count_s;
      div_r   <= div_s;
      mode_r  <= mode_s;
      pend_r  <= pend_s;
      pdiv_r  <= pdiv_s;
      pmode_r <= pmode_s;
      clk_r   <= clk_s;
      tick_r  <= tick_s;
`ifdef CLKDIV_DUTY_EN
      high_r  <= high_s;
      phigh_r <= phigh_s;
`endif
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent run-time programmable integer clock dividers.
// Optional feature macro: CLKDIV_DUTY_EN (cfg_high port, PULSE high time).
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   enable         global count enable
//   restart        phase-align all channels
//   cfg_valid/cfg_ready  config handshake; ready reflects cfg_ch's pending slot
//   cfg_ch         target channel (out-of-range: accepted and dropped)
//   cfg_div        new divisor (0 stops the channel)
//   cfg_mode       0 = TOGGLE, 1 = PULSE
//   cfg_high       PULSE high time (CLKDIV_DUTY_EN only)
//   divided_clk    per-channel divided outputs (registered)
//   tick           per-channel terminal strobes (registered)
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          restart,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  input  logic                          cfg_mode,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0]              cfg_high,
`endif
  output logic [NUM_CH-1:0]             divided_clk,
  output logic [NUM_CH-1:0]             tick
);

  logic [NUM_CH-1:0] hit_s;
  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] wr_en_s;
  logic              accept_s;

  // One-hot decode of cfg_ch; an out-of-range index selects no channel.
  always_comb begin
    hit_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      hit_s[i] = (int'(cfg_ch) == i);
    end
  end

  assign cfg_ready = ~|(pend_s & hit_s);
  assign accept_s  = cfg_valid && cfg_ready;
  assign wr_en_s   = hit_s & {NUM_CH{accept_s}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .restart     (restart),
      .wr_en       (wr_en_s[g]),
      .wr_div      (cfg_div),
      .wr_mode     (mode_e'(cfg_mode)),
`ifdef CLKDIV_DUTY_EN
      .wr_high     (cfg_high),
`endif
      .pending     (pend_s[g]),
      .divided_clk (divided_clk[g]),
      .tick        (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider (NUM_CH=4, CNT_W=8, DEFAULT_DIV=5).
// A table of hand-derived vectors, directed corner sequences and a randomized
// run are all checked against a phase-based reference model.
module tb_multi_clock_divider;
  import multi_clock_divider_pkg::*;

  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int DDIV = 5;

  logic          clk = 1'b0;
  logic          reset, enable, restart, cfg_valid, cfg_mode, cfg_ready;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [NCH-1:0] divided_clk, tick;
`ifdef CLKDIV_DUTY_EN
  logic [CW-1:0] cfg_high;
`endif

  always #5 clk = ~clk;

  multi_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode),
`ifdef CLKDIV_DUTY_EN
    .cfg_high(cfg_high),
`endif
    .divided_clk(divided_clk), .tick(tick));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is described by the number of enabled
  // cycles since its last alignment point (n) and the output level at that
  // point (base). A terminal happens whenever n is a multiple of div.
  int  m_div[NCH], m_pdiv[NCH], m_n[NCH];
  bit  m_mode[NCH], m_pmode[NCH], m_pend[NCH], m_base[NCH], m_out[NCH], m_tick[NCH];
  bit  m_init = 1'b0;

  function automatic bit m_ready(input int ch);
    return !m_pend[ch];
  endfunction

  function automatic logic [NCH-1:0] m_clk_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_out[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_tick_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  task automatic model_edge(input bit acc);
    for (int i = 0; i < NCH; i++) begin
      bit acc_i, had, term, par;
      acc_i = acc && (int'(cfg_ch) == i);
      if (!reset) begin
        m_div[i] = DDIV; m_mode[i] = 1'b0; m_pend[i] = 1'b0;
        m_n[i] = 0; m_base[i] = 1'b0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (restart) begin
        m_n[i] = 0; m_base[i] = 1'b0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
        if (acc_i) begin
          m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode;
        end else if (m_pend[i]) begin
          m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i];
        end
        m_pend[i] = 1'b0;
      end else begin
        had = m_pend[i];
        m_tick[i] = 1'b0;
        if (m_div[i] == 0) begin
          m_n[i] = 0; m_base[i] = 1'b0; m_out[i] = 1'b0;
          if (had) begin
            m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i]; m_pend[i] = 1'b0;
          end
        end else if (enable) begin
          m_n[i]++;
          term = (m_n[i] % m_div[i]) == 0;
          par  = ((m_n[i] / m_div[i]) % 2) != 0;
          m_tick[i] = term;
          if (term && had) begin
            if (m_pmode[i] != m_mode[i]) begin
              m_out[i] = 1'b0; m_base[i] = 1'b0;
            end else begin
              m_base[i] = m_base[i] ^ par;
              m_out[i]  = m_mode[i] ? 1'b1 : m_base[i];
            end
            m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i];
            m_n[i] = 0; m_pend[i] = 1'b0;
          end else begin
            m_out[i] = m_mode[i] ? term : (m_base[i] ^ par);
          end
        end
        if (acc_i) begin
          m_pend[i] = 1'b1; m_pdiv[i] = int'(cfg_div); m_pmode[i] = cfg_mode;
        end
      end
    end
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic step();
    bit acc;
    #1;
    if (m_init) chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
    acc = cfg_valid && m_ready(int'(cfg_ch));
    @(posedge clk);
    model_edge(acc);
    m_init = 1'b1;
    #1;
    chk("divided_clk", 32'(divided_clk), 32'(m_clk_vec()));
    chk("tick", 32'(tick), 32'(m_tick_vec()));
  endtask

  // Cycles between two consecutive ticks of one channel (-1 on timeout).
  task automatic measure_gap(input int ch, output int gap);
    int k;
    gap = -1;
    for (k = 0; k < 60; k++) begin
      step();
      if (tick[ch]) break;
    end
    if (k < 60) begin
      for (int j = 1; j <= 60; j++) begin
        step();
        if (tick[ch]) begin
          gap = j;
          break;
        end
      end
    end
  endtask

  typedef struct {
    logic           en;
    logic           rs;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic [NCH-1:0] saved;
    int ones;

    tbl = '{
      '{1'b1, 1'b0, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'h0, 4'h0},
      '{1'b1, 1'b0, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'hF, 4'hF}, '{1'b0, 1'b0, 4'hF, 4'h0},
      '{1'b0, 1'b0, 4'hF, 4'h0}, '{1'b1, 1'b0, 4'hF, 4'h0}, '{1'b1, 1'b0, 4'hF, 4'h0},
      '{1'b1, 1'b0, 4'hF, 4'h0}, '{1'b1, 1'b0, 4'hF, 4'h0}, '{1'b1, 1'b0, 4'h0, 4'hF},
      '{1'b1, 1'b1, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'h0, 4'h0},
      '{1'b1, 1'b0, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'h0, 4'h0}, '{1'b1, 1'b0, 4'hF, 4'hF}
    };

    reset = 1'b0; enable = 1'b1; restart = 1'b0; cfg_valid = 1'b0;
    cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0;
`ifdef CLKDIV_DUTY_EN
    cfg_high = 8'd1;
`endif
    step();
    step();
    reset = 1'b1;

    // Default divide-by-5 behaviour, freeze and restart from the table.
    for (int i = 0; i < 18; i++) begin
      enable  = tbl[i].en;
      restart = tbl[i].rs;
      step();
      chk("tbl_clk", 32'(divided_clk), 32'(tbl[i].exp_clk));
      chk("tbl_tick", 32'(tick), 32'(tbl[i].exp_tick));
    end
    restart = 1'b0;
    enable  = 1'b1;

    // ch2 -> div 3: ready low while pending, then tick spacing 3.
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; cfg_mode = 1'b0;
    step();
    cfg_valid = 1'b0;
    chk("ch2_ready_low", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (cfg_ready === 1'b1) break;
      step();
    end
    chk("ch2_applied", 32'(cfg_ready), 32'd1);
    measure_gap(2, gap);
    chk("ch2_gap", 32'(gap), 32'd3);

    // ch1 -> PULSE div 4; a second request stalls until the first applies.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4; cfg_mode = 1'b1;
    step();
    cfg_div = 8'd6; cfg_mode = 1'b0;
    #1;
    chk("ch1_stall", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (cfg_ready === 1'b1) break;
      step();
    end
    cfg_valid = 1'b0;
    chk("ch1_applied", 32'(cfg_ready), 32'd1);
    measure_gap(1, gap);
    chk("ch1_gap", 32'(gap), 32'd4);
    chk("ch1_pulse_is_tick", 32'(divided_clk[1]), 32'(tick[1]));

    // Freeze for 7 cycles.
    saved  = divided_clk;
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("freeze_tick", 32'(tick), 32'd0);
    end
    chk("freeze_clk", 32'(divided_clk), 32'(saved));
    enable = 1'b1;

    // Restart with ch0 div 2 pending: outputs cleared, period 4 immediately.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_mode = 1'b0;
    step();
    cfg_valid = 1'b0;
    restart   = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_clk", 32'(divided_clk), 32'd0);
    chk("restart_tick", 32'(tick), 32'd0);
    measure_gap(0, gap);
    chk("ch0_gap", 32'(gap), 32'd2);

    // ch3 stopped, then reset mid-period restores defaults.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0; cfg_mode = 1'b0;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cfg_ready === 1'b1) break;
      step();
    end
    step(); step(); step();
    chk("ch3_stopped_clk", 32'(divided_clk[3]), 32'd0);
    chk("ch3_stopped_tick", 32'(tick[3]), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = 2'(c);
      #1;
      chk("post_reset_ready", 32'(cfg_ready), 32'd1);
    end
    measure_gap(3, gap);
    chk("ch3_default_gap", 32'(gap), 32'd5);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 299) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      restart   = ($urandom_range(0, 59) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
      cfg_mode  = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b1; restart = 1'b0; cfg_valid = 1'b0; enable = 1'b1;

`ifdef CLKDIV_DUTY_EN
    // PULSE div 8 high 3 -> 3 of 8 cycles high; high 9 -> constant 1.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd8; cfg_mode = 1'b1; cfg_high = 8'd3;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; cfg_valid = 1'b0;
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (divided_clk[1]) ones++;
    end
    chk("duty_3_of_8", 32'(ones), 32'd6);
    cfg_valid = 1'b1; cfg_high = 8'd9;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0; cfg_valid = 1'b0;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (divided_clk[1]) ones++;
    end
    chk("duty_const_1", 32'(ones), 32'd8);
`else
    ones = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
